// File: rtl/serial_word_loader.sv
// Serial-to-parallel word loader: MSB-first capture under start/valid, one-cycle load_enable strobe.
// Optional even-parity check enabled by defining PARITY_CHECK_EN.
//   state  | meaning
//   IDLE   | waiting for start
//   SHIFT  | accepting WORD_LENGTH data bits on serial_valid
//   PARITY | accepting the parity bit (PARITY_CHECK_EN only)
//   LOAD   | Data_Output holds the new word, load_enable high for one cycle
module serial_word_loader #(
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   serial_in,
    input  logic                   serial_valid,
    output logic                   busy,
    output logic                   load_enable,
`ifdef PARITY_CHECK_EN
    output logic                   parity_error,
`endif
    output logic [WORD_LENGTH-1:0] Data_Output
);

    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
        S_PARITY = 2'd2,
`endif
        S_LOAD   = 2'd3
    } state_t;

    state_t                 state, state_next;
    logic [WORD_LENGTH-1:0] shift_reg;
    logic [WORD_LENGTH-1:0] shift_next;
    logic [WORD_LENGTH-1:0] load_value;
    logic [CW-1:0]          count;
    logic                   capture_bit;
    logic                   load_word;
`ifdef PARITY_CHECK_EN
    logic                   parity_fail;
    logic                   parity_error_q;
`endif

    assign shift_next = {shift_reg[WORD_LENGTH-2:0], serial_in};

    always_comb begin
        state_next  = state;
        capture_bit = 1'b0;
        load_word   = 1'b0;
        load_value  = shift_next;
`ifdef PARITY_CHECK_EN
        parity_fail = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (serial_valid) begin
                    capture_bit = 1'b1;
                    if (count == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                        state_next = S_PARITY;
`else
                        state_next = S_LOAD;
                        load_word  = 1'b1;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                load_value = shift_reg;
                if (serial_valid) begin
                    // Even parity: data XOR parity bit must reduce to zero.
                    if ((^shift_reg) ^ serial_in) begin
                        state_next  = S_IDLE;
                        parity_fail = 1'b1;
                    end else begin
                        state_next = S_LOAD;
                        load_word  = 1'b1;
                    end
                end
            end
`endif
            S_LOAD: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            shift_reg   <= '0;
            count       <= '0;
            Data_Output <= '0;
`ifdef PARITY_CHECK_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == S_IDLE && start) count <= '0;
            if (capture_bit) begin
                shift_reg <= shift_next;
                count     <= count + CW'(1);
            end
            if (load_word) Data_Output <= load_value;
`ifdef PARITY_CHECK_EN
            parity_error_q <= parity_fail;
`endif
        end
    end

    assign busy        = (state != S_IDLE);
    assign load_enable = (state == S_LOAD);
`ifdef PARITY_CHECK_EN
    assign parity_error = parity_error_q;
`endif

endmodule
